// File: rtl/burst_mem_responder.sv
// Burst responder: serves independent write and read bursts from a word-addressed array.
// Each channel runs its own request -> optional delay -> grant -> data FSM.
module burst_mem_responder #(
  parameter int unsigned addr_width = 32,
  parameter int unsigned data_width = 32,
  parameter int unsigned mem_depth  = 1024,
  parameter int unsigned gnt_delay  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  output logic                  wr_gnt,
  input  logic [15:0]           wr_len,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic                  wr_ready,
  output logic                  wr_done,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  input  logic [15:0]           rd_len,
  input  logic [addr_width-1:0] rd_addr,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_done,
  output logic                  len_err
);

  localparam int unsigned idx_w      = $clog2(mem_depth);
  localparam int unsigned beat_shift = $clog2(data_width / 8);
  localparam int unsigned len_w      = 16;
  localparam logic [3:0]  dly_last   = 4'(gnt_delay - 1);

  typedef enum logic [2:0] {W_IDLE, W_WAIT, W_GNT, W_DATA, W_DONE} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_GNT, R_DATA} rd_state_e;

  function automatic logic [len_w-1:0] beats_of(input logic [len_w-1:0] len);
    logic [len_w-1:0] b;
    b = len >> beat_shift;
    return (b == '0) ? len_w'(1) : b;
  endfunction

  logic [data_width-1:0] mem_array [mem_depth];
  logic                  unused_addr_hi;

  // Only the low address bits select a word; the array wraps.
  assign unused_addr_hi = ^{wr_addr[addr_width-1:idx_w], rd_addr[addr_width-1:idx_w]};

  // ---------------- write channel ----------------
  wr_state_e         wr_state_q, wr_state_d;
  logic [3:0]        wr_dly_q, wr_dly_d;
  logic [idx_w-1:0]  wr_base_q, wr_base_d;
  logic [len_w-1:0]  wr_beats_q, wr_beats_d;
  logic [len_w-1:0]  wr_cnt_q, wr_cnt_d;
  logic              len_err_q, len_err_d;
  logic              wr_hs, wr_in_len, wr_we;
  logic [idx_w-1:0]  wr_idx;

  assign wr_hs     = wr_valid && wr_ready;
  assign wr_in_len = wr_cnt_q < wr_beats_q;
  assign wr_we     = wr_hs && wr_in_len;
  assign wr_idx    = wr_base_q + idx_w'(wr_cnt_q);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_state_q <= W_IDLE;
    else        wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      W_IDLE:  if (wr_req) wr_state_d = (gnt_delay == 0) ? W_GNT : W_WAIT;
      W_WAIT:  if (wr_dly_q == dly_last) wr_state_d = W_GNT;
      W_GNT:   wr_state_d = W_DATA;
      W_DATA:  if (wr_hs && wr_last) wr_state_d = W_DONE;
      W_DONE:  wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_dly_d   = '0;
    wr_base_d  = wr_base_q;
    wr_beats_d = wr_beats_q;
    wr_cnt_d   = wr_cnt_q;
    len_err_d  = len_err_q;
    if (wr_state_q == W_WAIT) wr_dly_d = wr_dly_q + 4'd1;
    if (wr_state_q == W_GNT) begin
      wr_base_d  = wr_addr[idx_w-1:0];
      wr_beats_d = beats_of(wr_len);
      wr_cnt_d   = '0;
    end
    if (wr_hs) begin
      // Count saturates at the burst length; extra beats only raise the error.
      if (wr_in_len) wr_cnt_d = wr_cnt_q + len_w'(1);
      if (!wr_in_len || (wr_last && (wr_cnt_q != wr_beats_q - len_w'(1)))) len_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_dly_q   <= '0;
      wr_base_q  <= '0;
      wr_beats_q <= '0;
      wr_cnt_q   <= '0;
      len_err_q  <= 1'b0;
    end else begin
      wr_dly_q   <= wr_dly_d;
      wr_base_q  <= wr_base_d;
      wr_beats_q <= wr_beats_d;
      wr_cnt_q   <= wr_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  always_comb begin
    wr_gnt   = (wr_state_q == W_GNT);
    wr_ready = (wr_state_q == W_DATA);
    wr_done  = (wr_state_q == W_DONE);
  end

  assign len_err = len_err_q;

  // ---------------- read channel ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [3:0]            rd_dly_q, rd_dly_d;
  logic [idx_w-1:0]      rd_base_q, rd_base_d;
  logic [len_w-1:0]      rd_beats_q, rd_beats_d;
  logic [len_w-1:0]      rd_issue_q, rd_issue_d;
  logic [len_w-1:0]      rd_pop_q, rd_pop_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  out_v_q, out_v_d;
  logic [data_width-1:0] rd_data_q, rd_data_d;
  logic                  skid_v_q, skid_v_d;
  logic [data_width-1:0] skid_data_q, skid_data_d;
  logic [data_width-1:0] rd_word_q;
  logic                  rd_issue, rd_pop, rd_final;
  logic [idx_w-1:0]      rd_idx;
  logic [1:0]            rd_occ;

  assign rd_pop   = out_v_q && rd_ready;
  assign rd_final = (rd_pop_q == rd_beats_q - len_w'(1));
  assign rd_occ   = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, rd_pend_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state_q <= R_IDLE;
    else        rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      R_IDLE:  if (rd_req) rd_state_d = (gnt_delay == 0) ? R_GNT : R_WAIT;
      R_WAIT:  if (rd_dly_q == dly_last) rd_state_d = R_GNT;
      R_GNT:   rd_state_d = R_DATA;
      R_DATA:  if (rd_pop && rd_final) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rd_dly_d    = '0;
    rd_base_d   = rd_base_q;
    rd_beats_d  = rd_beats_q;
    rd_issue_d  = rd_issue_q;
    rd_pop_d    = rd_pop_q;
    rd_issue    = 1'b0;
    rd_idx      = rd_base_q + idx_w'(rd_issue_q);
    out_v_d     = out_v_q;
    rd_data_d   = rd_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    if (rd_state_q == R_WAIT) rd_dly_d = rd_dly_q + 4'd1;
    if (rd_state_q == R_GNT) begin
      // Beat 0 is fetched straight from the request so it appears two cycles after grant.
      rd_base_d  = rd_addr[idx_w-1:0];
      rd_beats_d = beats_of(rd_len);
      rd_issue_d = len_w'(1);
      rd_pop_d   = '0;
      rd_issue   = 1'b1;
      rd_idx     = rd_addr[idx_w-1:0];
    end else if (rd_state_q == R_DATA) begin
      // Output + skid hold two words; fetch only if the word will have a slot.
      rd_issue = (rd_issue_q < rd_beats_q) && ((rd_occ < 2'd2) || ((rd_occ == 2'd2) && rd_pop));
      if (rd_issue) rd_issue_d = rd_issue_q + len_w'(1);
    end
    if (rd_pop) rd_pop_d = rd_pop_q + len_w'(1);
    if (!out_v_q || rd_pop) begin
      if (skid_v_q) begin
        out_v_d     = 1'b1;
        rd_data_d   = skid_data_q;
        skid_v_d    = rd_pend_q;
        skid_data_d = rd_word_q;
      end else begin
        out_v_d = rd_pend_q;
        if (rd_pend_q) rd_data_d = rd_word_q;
      end
    end else if (rd_pend_q) begin
      skid_v_d    = 1'b1;
      skid_data_d = rd_word_q;
    end
    rd_pend_d = rd_issue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dly_q    <= '0;
      rd_base_q   <= '0;
      rd_beats_q  <= '0;
      rd_issue_q  <= '0;
      rd_pop_q    <= '0;
      rd_pend_q   <= 1'b0;
      out_v_q     <= 1'b0;
      rd_data_q   <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
    end else begin
      rd_dly_q    <= rd_dly_d;
      rd_base_q   <= rd_base_d;
      rd_beats_q  <= rd_beats_d;
      rd_issue_q  <= rd_issue_d;
      rd_pop_q    <= rd_pop_d;
      rd_pend_q   <= rd_pend_d;
      out_v_q     <= out_v_d;
      rd_data_q   <= rd_data_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
    end
  end

  // NOTE: the array and its read register carry no reset, so contents survive rst_n.
  // Both ports sample pre-edge contents, giving read-first behaviour on a collision.
  always_ff @(posedge clk) begin
    if (wr_we)    mem_array[wr_idx] <= wr_data;
    if (rd_issue) rd_word_q         <= mem_array[rd_idx];
  end

  always_comb begin
    rd_gnt   = (rd_state_q == R_GNT);
    rd_valid = out_v_q;
    rd_data  = rd_data_q;
    rd_done  = out_v_q && rd_final;
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder: directed bursts with random data,
// valid gaps and ready stalls, checked against an array model of the memory.
module tb_burst_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, wr_gnt, wr_valid, wr_last, wr_ready, wr_done;
  logic [15:0] wr_len, rd_len;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic        rd_req, rd_gnt, rd_valid, rd_ready, rd_done, len_err;

  logic        d3_wr_req, d3_wr_gnt, d3_wr_valid, d3_wr_last, d3_wr_ready, d3_wr_done;
  logic [15:0] d3_wr_len, d3_rd_len;
  logic [31:0] d3_wr_addr, d3_wr_data, d3_rd_addr, d3_rd_data;
  logic        d3_rd_req, d3_rd_gnt, d3_rd_valid, d3_rd_ready, d3_rd_done, d3_len_err;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] ref_mem [DEPTH];
  logic        exp_len_err = 1'b0;

  always #5 clk = ~clk;

  burst_mem_responder u_dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_len(wr_len), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
    .wr_done(wr_done),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_len(rd_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_done(rd_done),
    .len_err(len_err)
  );

  burst_mem_responder #(.gnt_delay(3)) u_dut_d3 (
    .clk(clk), .rst_n(rst_n),
    .wr_req(d3_wr_req), .wr_gnt(d3_wr_gnt), .wr_len(d3_wr_len), .wr_addr(d3_wr_addr),
    .wr_data(d3_wr_data), .wr_valid(d3_wr_valid), .wr_last(d3_wr_last),
    .wr_ready(d3_wr_ready), .wr_done(d3_wr_done),
    .rd_req(d3_rd_req), .rd_gnt(d3_rd_gnt), .rd_len(d3_rd_len), .rd_addr(d3_rd_addr),
    .rd_data(d3_rd_data), .rd_valid(d3_rd_valid), .rd_ready(d3_rd_ready),
    .rd_done(d3_rd_done), .len_err(d3_len_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(input int unsigned len);
    return ((len >> 2) == 0) ? 1 : int'(len >> 2);
  endfunction

  // Sends n_send beats with wr_last on the final one; rnd selects random data, else data = beat index.
  task automatic do_write(input int unsigned addr, input int unsigned len, input int n_send,
                          input bit full_rate, input bit rnd);
    int          beats, i, guard;
    logic [31:0] d;
    beats = beats_of(len);
    @(negedge clk);
    wr_req = 1'b1; wr_addr = addr; wr_len = 16'(len);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!wr_gnt && guard < 50);
    check("wr_gnt_latency", 64'(guard), 64'd1);
    wr_req = 1'b0;
    i = 0; guard = 0;
    d = rnd ? $urandom : 32'd0;
    while (i < n_send && guard < 1000) begin
      wr_valid = full_rate || ($urandom_range(0, 3) != 0);
      wr_data  = d;
      wr_last  = (i == n_send - 1);
      if (wr_valid && wr_ready) begin
        if (i < beats) ref_mem[(addr + i) % DEPTH] = d;
        if ((wr_last && i != beats - 1) || i >= beats) exp_len_err = 1'b1;
        i++;
        d = rnd ? $urandom : 32'(i);
      end
      @(negedge clk); guard++;
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    check("wr_beats_sent", 64'(i), 64'(n_send));
    check("wr_done_pulse", 64'(wr_done), 64'd1);
    check("len_err", 64'(len_err), 64'(exp_len_err));
    @(negedge clk);
    check("wr_done_single", 64'(wr_done), 64'd0);
    check("wr_ready_idle", 64'(wr_ready), 64'd0);
  endtask

  // mode 0: ready held high, 1: random ready, 2: repeating 1-0-0-1 ready pattern.
  task automatic do_read(input int unsigned addr, input int unsigned len, input int mode);
    int          beats, k, guard, t;
    logic [31:0] exp_q [$];
    logic [31:0] held;
    bit          stalled, seen_first;
    beats = beats_of(len);
    for (int j = 0; j < beats; j++) exp_q.push_back(ref_mem[(addr + j) % DEPTH]);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = addr; rd_len = 16'(len);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!rd_gnt && guard < 50);
    check("rd_gnt_latency", 64'(guard), 64'd1);
    rd_req = 1'b0;
    k = 0; t = 0; guard = 0; stalled = 1'b0; seen_first = 1'b0; held = '0;
    while (k < beats && guard < 2000) begin
      if (rd_valid && !seen_first) begin
        check("rd_first_valid_latency", 64'(t), 64'd2);
        seen_first = 1'b1;
      end
      if (stalled) begin
        check("rd_valid_held", 64'(rd_valid), 64'd1);
        check("rd_data_held", 64'(rd_data), 64'(held));
      end
      check("rd_done", 64'(rd_done), 64'(rd_valid && (k == beats - 1)));
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'($urandom_range(0, 1));
        default: rd_ready = ((t % 4) == 0) || ((t % 4) == 3);
      endcase
      if (rd_valid && rd_ready) begin
        check("rd_data", 64'(rd_data), 64'(exp_q[k]));
        k++;
      end
      stalled = rd_valid && !rd_ready;
      held    = rd_data;
      @(negedge clk); t++; guard++;
    end
    rd_ready = 1'b0;
    check("rd_beats", 64'(k), 64'(beats));
    check("rd_valid_idle", 64'(rd_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    wr_req = 0; wr_len = 0; wr_addr = 0; wr_data = 0; wr_valid = 0; wr_last = 0;
    rd_req = 0; rd_len = 0; rd_addr = 0; rd_ready = 0;
    d3_wr_req = 0; d3_wr_len = 0; d3_wr_addr = 0; d3_wr_data = 0; d3_wr_valid = 0;
    d3_wr_last = 0; d3_rd_req = 0; d3_rd_len = 0; d3_rd_addr = 0; d3_rd_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({wr_gnt, wr_ready, wr_done, rd_gnt, rd_valid, rd_done, len_err}), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    rst_n = 1'b1;

    // 32-beat burst at 0x40 with data = index, read back at full rate and with stalls.
    do_write(32'h40, 128, 32, 1'b1, 1'b0);
    do_read(32'h40, 128, 0);
    do_read(32'h40, 128, 2);
    do_read(32'h40, 0, 0);

    // Wrap at the top of the array.
    do_write(DEPTH - 2, 16, 4, 1'b0, 1'b1);
    do_read(DEPTH - 2, 16, 1);

    // Grant delay of 3 on the second instance: write then read one word.
    @(negedge clk);
    d3_wr_req = 1'b1; d3_wr_addr = 32'd5; d3_wr_len = 16'd4;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!d3_wr_gnt && guard < 50);
    check("d3_wr_gnt_latency", 64'(guard), 64'd4);
    d3_wr_req = 1'b0; d3_wr_valid = 1'b1; d3_wr_last = 1'b1; d3_wr_data = 32'hA5A5_0F0F;
    guard = 0;
    while (!d3_wr_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    d3_wr_valid = 1'b0; d3_wr_last = 1'b0;
    check("d3_wr_done", 64'(d3_wr_done), 64'd1);
    @(negedge clk);
    d3_rd_req = 1'b1; d3_rd_addr = 32'd5; d3_rd_len = 16'd4;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!d3_rd_gnt && guard < 50);
    check("d3_rd_gnt_latency", 64'(guard), 64'd4);
    d3_rd_req = 1'b0; d3_rd_ready = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!d3_rd_valid && guard < 50);
    check("d3_rd_first_valid", 64'(guard), 64'd2);
    check("d3_rd_data", 64'(d3_rd_data), 64'h0000_0000_A5A5_0F0F);
    check("d3_rd_done", 64'(d3_rd_done), 64'd1);
    @(negedge clk);
    d3_rd_ready = 1'b0;
    check("d3_rd_idle", 64'(d3_rd_valid), 64'd0);

    // Concurrent write and read of 0x80 granted together: read sees pre-write words.
    do_write(32'h80, 32, 8, 1'b0, 1'b1);
    fork
      do_write(32'h80, 32, 8, 1'b1, 1'b1);
      do_read(32'h80, 32, 0);
    join
    do_read(32'h80, 32, 1);

    // Length errors: early wr_last, then beats past the burst length.
    check("len_err_clean", 64'(len_err), 64'd0);
    do_write(32'h300, 16, 4, 1'b0, 1'b1);
    do_write(32'h200, 16, 3, 1'b0, 1'b1);
    do_write(32'h300, 8, 4, 1'b0, 1'b1);
    do_read(32'h200, 12, 0);
    do_read(32'h300, 16, 1);

    // Reset in the middle of a read burst.
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 32'h40; rd_len = 16'd128;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!rd_gnt && guard < 50);
    rd_req = 1'b0; rd_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset_valid", 64'(rd_valid), 64'd1);
    rst_n = 1'b0;
    exp_len_err = 1'b0;
    @(negedge clk);
    check("mid_reset_valid", 64'(rd_valid), 64'd0);
    check("mid_reset_outputs", 64'({rd_done, rd_gnt, wr_ready, len_err}), 64'd0);
    rd_ready = 1'b0;
    rst_n = 1'b1;
    do_read(32'h80, 32, 0);
    do_read(32'h40, 128, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
